// File: rtl/cla_sub_pipe_if.sv
// Streaming operand/result bundle for the pipelined subtractor.
// The master side drives operands and consumer-ready; the slave side is the subtractor.
interface cla_sub_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             iniB;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Diff;
   logic             Borrow;
   logic             Ovf;

   modport master (
      output in_valid, A, B, iniB, out_ready,
      input  in_ready, out_valid, Diff, Borrow, Ovf
   );

   modport slave (
      input  in_valid, A, B, iniB, out_ready,
      output in_ready, out_valid, Diff, Borrow, Ovf
   );
endinterface

// File: rtl/cla_sub_pipe.sv
// Three-stage pipelined subtractor: Diff = A - B - iniB computed as A + ~B + ~iniB,
// carries resolved by a kgp prefix network split between stage 1 and stage 2.
module cla_sub_pipe #(
   parameter int WIDTH = 32,
   parameter int SPLIT = 2
) (
   input logic           clk,
   input logic           rst,
   cla_sub_pipe_if.slave bus
);
   localparam int LOG_W = $clog2(WIDTH);

   typedef struct packed {
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
   } kgp_t;

   // Applies prefix levels first..last-1 (distance 1 << level); bits below the
   // distance keep their pair because the shifted-in operand is masked off.
   function automatic kgp_t prefix_levels(input kgp_t in_kgp, input int first, input int last);
      kgp_t             cur;
      kgp_t             nxt;
      logic [WIDTH-1:0] hi_mask;
      cur = in_kgp;
      for (int l = first; l < last; l++) begin
         hi_mask = {WIDTH{1'b1}} << (1 << l);
         nxt.g   = ((cur.g << (1 << l)) & cur.p) | cur.g;
         nxt.p   = ((((cur.p << (1 << l)) & cur.p) | cur.g) & hi_mask) | (cur.p & ~hi_mask);
         cur     = nxt;
      end
      return cur;
   endfunction

   // Stage valids and output registers
   logic             s1_valid_q, s2_valid_q, out_valid_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q, ovf_q;

   // Stage data registers
   kgp_t             s1_kgp_q, s2_kgp_q;
   logic [WIDTH-1:0] s1_x_q, s2_x_q;
   logic             s1_c0_q, s2_c0_q;
   logic             s1_amsb_q, s1_bmsb_q, s2_amsb_q, s2_bmsb_q;

   logic             s1_en, s2_en, s3_en, in_fire;
   logic [WIDTH-1:0] b_inv;
   logic             c0_d;
   kgp_t             gen_kgp, s1_kgp_d, s2_kgp_d;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] s3_diff_d;
   logic             s3_borrow_d, s3_ovf_d;

   // A stage loads when empty or when its occupant moves on this cycle, so the
   // ready chain runs combinationally from out_ready back to in_ready.
   assign s3_en        = !out_valid_q || bus.out_ready;
   assign s2_en        = !s2_valid_q || s3_en;
   assign s1_en        = !s1_valid_q || s2_en;
   assign bus.in_ready = !rst && s1_en;
   assign in_fire      = bus.in_valid && bus.in_ready;

   // NOTE: every variable written in this block is assigned before any partial
   // update, so no latch can be inferred.
   always_comb begin
      b_inv        = ~bus.B;
      c0_d         = ~bus.iniB;
      gen_kgp.g    = bus.A & b_inv;
      gen_kgp.p    = bus.A | b_inv;
      gen_kgp.g[0] = (bus.A[0] & b_inv[0]) | (c0_d & (bus.A[0] | b_inv[0]));
      gen_kgp.p[0] = gen_kgp.g[0];
   end

   assign s1_kgp_d = prefix_levels(gen_kgp, 0, SPLIT);
   assign s2_kgp_d = prefix_levels(s1_kgp_q, SPLIT, LOG_W);

   assign carry       = {s2_kgp_q.g & s2_kgp_q.p, s2_c0_q};
   assign s3_diff_d   = s2_x_q ^ carry[WIDTH-1:0];
   assign s3_borrow_d = ~carry[WIDTH];
   assign s3_ovf_d    = (s2_amsb_q != s2_bmsb_q) && (s3_diff_d[WIDTH-1] != s2_amsb_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         if (s1_en) s1_valid_q <= in_fire;
         if (s2_en) s2_valid_q <= s1_valid_q;
         if (s3_en) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
               diff_q   <= s3_diff_d;
               borrow_q <= s3_borrow_d;
               ovf_q    <= s3_ovf_d;
            end
         end
      end
   end

   // NOTE: intermediate data registers are deliberately left unreset; their
   // contents are only ever observed behind a stage valid bit that is reset.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1_kgp_q  <= s1_kgp_d;
         s1_x_q    <= bus.A ^ b_inv;
         s1_c0_q   <= c0_d;
         s1_amsb_q <= bus.A[WIDTH-1];
         s1_bmsb_q <= bus.B[WIDTH-1];
      end
      if (s2_en && s1_valid_q) begin
         s2_kgp_q  <= s2_kgp_d;
         s2_x_q    <= s1_x_q;
         s2_c0_q   <= s1_c0_q;
         s2_amsb_q <= s1_amsb_q;
         s2_bmsb_q <= s1_bmsb_q;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.Diff      = diff_q;
   assign bus.Borrow    = borrow_q;
   assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_cla_sub_pipe.sv
// Bench for cla_sub_pipe: three instances (SPLIT=1,2,4) share one stimulus stream;
// expected results are queued at input transfer and compared at output transfer.
module tb_cla_sub_pipe;
   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         borrow;
      logic         ovf;
   } exp_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         inib;
      logic [W-1:0] diff;
      logic         borrow;
      logic         ovf;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, out_ready, inib_drv;
   logic [W-1:0] a_drv, b_drv;
   exp_t         exp_cur;
   exp_t         sb[$];
   int           errors = 0;
   int           checks = 0;
   vec_t         vecs[11];

   cla_sub_pipe_if #(.WIDTH(W)) bus_s1 ();
   cla_sub_pipe_if #(.WIDTH(W)) bus_s2 ();
   cla_sub_pipe_if #(.WIDTH(W)) bus_s4 ();

   assign bus_s1.in_valid  = in_valid;
   assign bus_s1.A         = a_drv;
   assign bus_s1.B         = b_drv;
   assign bus_s1.iniB      = inib_drv;
   assign bus_s1.out_ready = out_ready;
   assign bus_s2.in_valid  = in_valid;
   assign bus_s2.A         = a_drv;
   assign bus_s2.B         = b_drv;
   assign bus_s2.iniB      = inib_drv;
   assign bus_s2.out_ready = out_ready;
   assign bus_s4.in_valid  = in_valid;
   assign bus_s4.A         = a_drv;
   assign bus_s4.B         = b_drv;
   assign bus_s4.iniB      = inib_drv;
   assign bus_s4.out_ready = out_ready;

   cla_sub_pipe #(.WIDTH(W), .SPLIT(1)) dut_s1 (.clk(clk), .rst(rst), .bus(bus_s1));
   cla_sub_pipe #(.WIDTH(W), .SPLIT(2)) dut_s2 (.clk(clk), .rst(rst), .bus(bus_s2));
   cla_sub_pipe #(.WIDTH(W), .SPLIT(4)) dut_s4 (.clk(clk), .rst(rst), .bus(bus_s4));

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: full-width unsigned subtraction; the extra bit is the borrow.
   function automatic vec_t mk_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic inib);
      vec_t       v;
      logic [W:0] r;
      r        = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, inib};
      v.a      = a;
      v.b      = b;
      v.inib   = inib;
      v.diff   = r[W-1:0];
      v.borrow = r[W];
      v.ovf    = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      return v;
   endfunction

   function automatic logic [W-1:0] rand_word();
      case ($urandom_range(7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard: push on input transfer, pop and compare on output transfer.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (bus_s2.out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got Diff=%0h with empty scoreboard at %0t", bus_s2.Diff, $time);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("out_split1", 64'({bus_s1.out_valid, bus_s1.Diff, bus_s1.Borrow, bus_s1.Ovf}), 64'({1'b1, e}));
               check("out_split2", 64'({bus_s2.out_valid, bus_s2.Diff, bus_s2.Borrow, bus_s2.Ovf}), 64'({1'b1, e}));
               check("out_split4", 64'({bus_s4.out_valid, bus_s4.Diff, bus_s4.Borrow, bus_s4.Ovf}), 64'({1'b1, e}));
            end
         end
         if (in_valid && bus_s2.in_ready) sb.push_back(exp_cur);
      end
   end

   task automatic drive(input vec_t v);
      a_drv    = v.a;
      b_drv    = v.b;
      inib_drv = v.inib;
      exp_cur  = {v.diff, v.borrow, v.ovf};
   endtask

   // Hold one operand set until accepted; returns just after the accepting edge.
   task automatic send(input vec_t v);
      int waited;
      waited = 0;
      drive(v);
      in_valid = 1'b1;
      @(negedge clk);
      while (!bus_s2.in_ready && waited < 100) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         waited++;
      end
      check("send_accept", 64'(bus_s2.in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_timed(input vec_t v, input string tag);
      send(v);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check({tag, "_latency"}, 64'(bus_s2.out_valid), 64'(k == 3));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 50 && sb.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      check("drain_empty", 64'(sb.size()), 64'(0));
   endtask

   initial begin
      int   acc, outd, held, saw_full, idx, cyc, ghosts;
      vec_t bp[8];
      vec_t v;

      vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
      vecs[1]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[3]  = '{32'h0000_0001, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
      vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
      vecs[5]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
      vecs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[7]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[10] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a_drv     = '0;
      b_drv     = '0;
      inib_drv  = 1'b0;
      exp_cur   = '0;

      // Reset behaviour
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("in_ready_during_reset", 64'({bus_s1.in_ready, bus_s2.in_ready, bus_s4.in_ready}), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", 64'({bus_s2.out_valid, bus_s2.Diff, bus_s2.Borrow, bus_s2.Ovf}), 64'(0));
      check("in_ready_after_reset", 64'({bus_s1.in_ready, bus_s2.in_ready, bus_s4.in_ready}), 64'(3'b111));
      @(posedge clk);
      #1;

      // Single set with latency check, then the vector table back to back
      send_timed(vecs[0], "basic");
      for (int i = 1; i < 11; i++) send(vecs[i]);
      drain();

      // Backpressure: 8 sets back to back, consumer stalls on cycles 4..8
      for (int k = 0; k < 8; k++)
         bp[k] = mk_vec(32'h1000_0000 * k + k, 32'h0000_0003 * k + 32'h8000_0000 * (k % 2), k[0]);
      acc = 0;
      outd = 0;
      saw_full = 0;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         if (idx < 8) begin
            drive(bp[idx]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = !(c >= 4 && c <= 8);
         @(negedge clk);
         held = acc - outd;
         if (!out_ready && held == 3) begin
            check("bp_full_in_ready", 64'(bus_s2.in_ready), 64'(0));
            saw_full++;
         end
         if (!out_ready && bus_s2.out_valid && sb.size() != 0)
            check("bp_stall_stable", 64'({bus_s2.Diff, bus_s2.Borrow, bus_s2.Ovf}), 64'(sb[0]));
         if (c == 9) check("bp_release_same_cycle", 64'({bus_s2.in_ready, bus_s2.out_valid}), 64'(2'b11));
         if (in_valid && bus_s2.in_ready) begin
            acc++;
            idx++;
         end
         if (bus_s2.out_valid && out_ready) outd++;
         if (c == 15) check("bp_throughput", 64'(outd), 64'(8));
         @(posedge clk);
         #1;
      end
      check("bp_full_cycles", 64'(saw_full), 64'(5));
      check("bp_accepted", 64'(acc), 64'(8));
      drain();

      // Reset with two sets in flight; neither may emerge
      send(mk_vec(32'hDEAD_BEEF, 32'h0000_1111, 1'b0));
      send(mk_vec(32'h0000_0001, 32'h0000_0002, 1'b1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("flush_out_valid", 64'({bus_s1.out_valid, bus_s2.out_valid, bus_s4.out_valid}), 64'(0));
      check("flush_in_ready", 64'(bus_s2.in_ready), 64'(1));
      ghosts = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (bus_s1.out_valid || bus_s2.out_valid || bus_s4.out_valid) ghosts++;
      end
      check("flush_no_ghosts", 64'(ghosts), 64'(0));
      @(posedge clk);
      #1;
      send_timed(mk_vec(32'h0000_0100, 32'h0000_0001, 1'b1), "post_reset");
      drain();

      // Random traffic with random in_valid / out_ready
      acc = 0;
      cyc = 0;
      while (acc < 10000 && cyc < 60000) begin
         v = mk_vec(rand_word(), rand_word(), 1'($urandom_range(1)));
         drive(v);
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         @(negedge clk);
         if (in_valid && bus_s2.in_ready) acc++;
         @(posedge clk);
         #1;
         cyc++;
      end
      check("rand_accepted", 64'(acc), 64'(10000));
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
